rx_packet_parser: RTL and testbench
===================================

# rx_packet_parser

Receives the correlator's serialized packet stream, one byte per strobe, and reassembles it into a full-width packet word. It decodes both the ASCII-hex framing and the raw binary framing that the packet generator produces. The block validates length and characters, and presents each complete packet as a one-cycle-valid parallel word. It sits behind a uart_rx or spi_slave instance for board-to-board chaining and for loopback self-test of the transmit path.

## Interface
- RESOLUTION, 256: packet width in bits (the PACKET_SIZE of the sender); multiple of 8, ≥ 16.
- BINARY, 0: 0 = ASCII-hex framing with 0x0D terminator; 1 = raw bytes, fixed count, no terminator.
- TIMEOUT_CYCLES, 65535: idle cycles tolerated mid-packet; used only with the timeout feature; range 1..2^20-1.

- intclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rxreg  in  8  received byte; valid when rxif = 1.
- rxif  in  1  one-cycle byte strobe.
- data_out  out  RESOLUTION  last good packet, MSB first as transmitted; reset 0.
- data_valid  out  1  one-cycle pulse when data_out updates; reset 0.
- char_err  out  1  one-cycle pulse on an illegal hex character; reset 0.
- length_err  out  1  one-cycle pulse on a wrong nibble count at the terminator; reset 0.
- timeout_err  out  1  one-cycle pulse on a mid-packet timeout; reset 0.
- busy  out  1  high while a packet is partially received; reset 0.
- packet_count  out  16  number of good packets, wraps at 0xFFFF→0; reset 0.

## Operation
- States: IDLE, RECV, SKIP.
- A shift register `sr` of RESOLUTION bits and a counter `cnt` of clog2(RESOLUTION/4)+2 bits.
- Hex mode (BINARY = 0):
  - Legal characters: '0'-'9', 'A'-'F', 'a'-'f'.
  - A legal char shifts its nibble in: sr <= {sr[RESOLUTION-5:0], nib}, cnt++. IDLE goes to RECV and cnt starts at 1.
  - 0x0D in IDLE is ignored; no error.
  - 0x0D in RECV with cnt == RESOLUTION/4: data_out <= sr, data_valid pulse, packet_count++, go to IDLE.
  - 0x0D in RECV with cnt != RESOLUTION/4: length_err pulse, data_out held, go to IDLE.
  - 0x0A is ignored in every state.
  - Any other byte in IDLE or RECV: char_err pulse, go to SKIP.
  - SKIP: discard bytes until 0x0D, then go to IDLE with no further pulse.
  - cnt saturates at RESOLUTION/4+1. Overlong packets therefore give length_err at the terminator.
- Binary mode (BINARY = 1):
  - Every byte shifts 8 bits in and cnt++.
  - When cnt reaches RESOLUTION/8: data_out updates, data_valid pulses, packet_count++, go to IDLE.
  - No terminator; char_err and length_err are never asserted.
- busy = (state != IDLE).
- sr is not cleared between packets. Only a complete packet reaches data_out.

## Timing
- Latency: the byte strobed at edge N (the terminator, or the last binary byte) gives data_out and data_valid valid after edge N+1, i.e. registered one cycle.
- Error pulses have the same one-cycle latency and are mutually exclusive with data_valid.
- Back-to-back rxif on consecutive cycles is supported, at full rate with no stall.
- Reset mid-packet: the state returns to IDLE and all outputs go to their reset values, including data_out and packet_count. An rxif on the reset cycle is ignored.
- Timeout counter:
  - Clears on every rxif.
  - Counts while busy.
  - On reaching TIMEOUT_CYCLES: timeout_err pulse, go to IDLE, partial data discarded.
  - If rxif and expiry fall in the same cycle, rxif wins: the byte is processed and there is no timeout.
  - Timeout also applies in SKIP, returning to IDLE without a char_err.

## Configuration
- RX_PACKET_TIMEOUT_EN defined: the timeout counter and timeout_err are built as described above.
- Not defined: no counter is built, and timeout_err is tied to 0. A partial packet waits indefinitely for its terminator or remaining bytes.

## Test plan
- Hex, RESOLUTION=16: bytes '1','2','A','B',0x0D → data_out=0x12AB, data_valid for one cycle, packet_count=1, busy falls.
- Hex: '1','2','a',0x0D → length_err pulse, data_out stays 0x12AB; then 'a','b','c','d',0x0D → 0xABCD.
- Hex: '1','G','4',0x0D,'5','6','7','8',0x0D → a single char_err, then data_out=0x5678 with no length_err.
- Binary (BINARY=1, RESOLUTION=24): 0x12,0x34,0x56 on back-to-back cycles → data_out=0x123456, valid one cycle after the third byte.
- Timeout (macro on, TIMEOUT_CYCLES=8): '1','2', then idle for 8 cycles → timeout_err pulse, busy=0; then 'F','F','F','F',0x0D → 0xFFFF. With the macro off the same stimulus gives no pulse and busy stays 1.
- Reset asserted after '1','2' → all outputs 0; then '0','0','0','1',0x0D → data_out=0x0001, packet_count=1.

Source files
------------

// File: rtl/rx_packet_parser.sv
// Reassembles a byte-serial packet stream (ASCII-hex or raw binary framing) into a parallel word.
// Optional define RX_PACKET_TIMEOUT_EN builds the mid-packet idle timeout and timeout_err.
//
// state | meaning
// IDLE  | waiting for the first byte of a packet
// RECV  | packet partially received
// SKIP  | bad hex character seen, discarding up to the next 0x0D
module rx_packet_parser #(
  parameter int RESOLUTION     = 256,
  parameter int BINARY         = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  intclk,
  input  logic                  reset,
  input  logic [7:0]            rxreg,
  input  logic                  rxif,
  output logic [RESOLUTION-1:0] data_out,
  output logic                  data_valid,
  output logic                  char_err,
  output logic                  length_err,
  output logic                  timeout_err,
  output logic                  busy,
  output logic [15:0]           packet_count
);

  localparam int CW = $clog2(RESOLUTION/4) + 2;
  localparam logic [CW-1:0] NIB_FULL  = CW'(RESOLUTION/4);
  localparam logic [CW-1:0] NIB_SAT   = CW'(RESOLUTION/4 + 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(RESOLUTION/8 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {IDLE, RECV, SKIP} state_t;

  state_t                state, state_nxt;
  logic [RESOLUTION-1:0] sr, sr_nxt, dout_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [15:0]           pcnt_nxt;
  logic                  valid_nxt, cerr_nxt, lerr_nxt, terr_nxt;
  logic [3:0]            nib;
  logic                  legal;
  logic                  expire;

  assign busy = (state != IDLE);

`ifdef RX_PACKET_TIMEOUT_EN
  // Down-counter reloaded by every byte; expiry is the cycle it sits at zero while busy.
  logic [19:0] tmr, tmr_nxt;

  always_comb begin
    tmr_nxt = tmr;
    expire  = 1'b0;
    if (rxif)
      tmr_nxt = 20'(TIMEOUT_CYCLES - 1);
    else if (busy) begin
      if (tmr == 20'd0) expire = 1'b1;
      else              tmr_nxt = tmr - 20'd1;
    end
  end

  always_ff @(posedge intclk) begin
    if (reset) tmr <= '0;
    else       tmr <= tmr_nxt;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    if (rxreg >= 8'h30 && rxreg <= 8'h39)
      nib = rxreg[3:0];
    else if ((rxreg >= 8'h41 && rxreg <= 8'h46) || (rxreg >= 8'h61 && rxreg <= 8'h66))
      nib = rxreg[3:0] + 4'd9;
    else
      legal = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    dout_nxt  = data_out;
    pcnt_nxt  = packet_count;
    valid_nxt = 1'b0;
    cerr_nxt  = 1'b0;
    lerr_nxt  = 1'b0;
    terr_nxt  = 1'b0;
    if (rxif) begin
      if (BINARY != 0) begin
        sr_nxt = {sr[RESOLUTION-9:0], rxreg};
        if (state == RECV && cnt == BYTE_LAST) begin
          dout_nxt  = sr_nxt;
          valid_nxt = 1'b1;
          pcnt_nxt  = packet_count + 16'd1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = RECV;
          cnt_nxt   = (state == RECV) ? cnt + CNT_ONE : CNT_ONE;
        end
      end else begin
        case (state)
          IDLE, RECV: begin
            if (rxreg == 8'h0A) begin
              state_nxt = state;
            end else if (rxreg == 8'h0D) begin
              if (state == RECV) begin
                state_nxt = IDLE;
                if (cnt == NIB_FULL) begin
                  dout_nxt  = sr;
                  valid_nxt = 1'b1;
                  pcnt_nxt  = packet_count + 16'd1;
                end else begin
                  lerr_nxt = 1'b1;
                end
              end
            end else if (legal) begin
              sr_nxt    = {sr[RESOLUTION-5:0], nib};
              state_nxt = RECV;
              if (state == IDLE)      cnt_nxt = CNT_ONE;
              else if (cnt != NIB_SAT) cnt_nxt = cnt + CNT_ONE;
            end else begin
              cerr_nxt  = 1'b1;
              state_nxt = SKIP;
            end
          end
          default: begin
            if (rxreg == 8'h0D) state_nxt = IDLE;
          end
        endcase
      end
    end else if (expire) begin
      state_nxt = IDLE;
      terr_nxt  = 1'b1;
    end
  end

  always_ff @(posedge intclk) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      char_err     <= 1'b0;
      length_err   <= 1'b0;
      timeout_err  <= 1'b0;
      packet_count <= '0;
    end else begin
      state        <= state_nxt;
      sr           <= sr_nxt;
      cnt          <= cnt_nxt;
      data_out     <= dout_nxt;
      data_valid   <= valid_nxt;
      char_err     <= cerr_nxt;
      length_err   <= lerr_nxt;
      timeout_err  <= terr_nxt;
      packet_count <= pcnt_nxt;
    end
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
// Bench for rx_packet_parser: a 16-bit hex instance and a 24-bit binary instance,
// expected output events queued as bytes are driven and matched when the pulses appear.
module tb_rx_packet_parser;

  localparam logic [3:0] EV_VALID = 4'b1000;
  localparam logic [3:0] EV_CERR  = 4'b0100;
  localparam logic [3:0] EV_LERR  = 4'b0010;
  localparam logic [3:0] EV_TERR  = 4'b0001;

  typedef struct {
    logic [3:0]  flags;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  h_rxreg = 8'h00, b_rxreg = 8'h00;
  logic        h_rxif = 1'b0, b_rxif = 1'b0;
  logic [15:0] h_data;
  logic [23:0] b_data;
  logic        h_valid, h_cerr, h_lerr, h_terr, h_busy;
  logic        b_valid, b_cerr, b_lerr, b_terr, b_busy;
  logic [15:0] h_pcnt, b_pcnt;

  int checks = 0;
  int errors = 0;
  ev_t q_hex[$];
  ev_t q_bin[$];
  logic [15:0] exp_hpcnt = 16'd0;
  logic [15:0] exp_bpcnt = 16'd0;
  logic [15:0] exp_hdata = 16'd0;

  always #5 clk = ~clk;

  rx_packet_parser #(.RESOLUTION(16), .BINARY(0), .TIMEOUT_CYCLES(8)) u_hex (
    .intclk(clk), .reset(rst), .rxreg(h_rxreg), .rxif(h_rxif),
    .data_out(h_data), .data_valid(h_valid), .char_err(h_cerr), .length_err(h_lerr),
    .timeout_err(h_terr), .busy(h_busy), .packet_count(h_pcnt)
  );

  rx_packet_parser #(.RESOLUTION(24), .BINARY(1), .TIMEOUT_CYCLES(8)) u_bin (
    .intclk(clk), .reset(rst), .rxreg(b_rxreg), .rxif(b_rxif),
    .data_out(b_data), .data_valid(b_valid), .char_err(b_cerr), .length_err(b_lerr),
    .timeout_err(b_terr), .busy(b_busy), .packet_count(b_pcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_hex(input logic [3:0] f, input logic [15:0] d);
    ev_t e;
    e.flags = f;
    e.data  = {16'h0, d};
    q_hex.push_back(e);
  endtask

  task automatic push_bin(input logic [3:0] f, input logic [23:0] d);
    ev_t e;
    e.flags = f;
    e.data  = {8'h0, d};
    q_bin.push_back(e);
  endtask

  // Drive one byte for exactly one sampling edge; returns at the following negedge.
  task automatic send_h(input logic [7:0] b);
    h_rxreg = b;
    h_rxif  = 1'b1;
    @(negedge clk);
    h_rxif  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rxreg = b;
    b_rxif  = 1'b1;
    @(negedge clk);
    b_rxif  = 1'b0;
  endtask

  task automatic valid_pkt(input logic [15:0] d);
    exp_hpcnt = exp_hpcnt + 16'd1;
    exp_hdata = d;
    push_hex(EV_VALID, d);
  endtask

  task automatic drain_and_check(input string tag);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_queue_empty"}, 32'(q_hex.size() + q_bin.size()), 32'd0);
    check({tag, "_data_out"}, {16'h0, h_data}, {16'h0, exp_hdata});
    check({tag, "_packet_count"}, {16'h0, h_pcnt}, {16'h0, exp_hpcnt});
    check({tag, "_busy"}, {31'h0, h_busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (h_valid | h_cerr | h_lerr | h_terr) begin
        if (q_hex.size() == 0)
          check("hex_unexpected_event", {28'h0, h_valid, h_cerr, h_lerr, h_terr}, 32'd0);
        else begin
          e = q_hex.pop_front();
          check("hex_event_kind", {28'h0, h_valid, h_cerr, h_lerr, h_terr}, {28'h0, e.flags});
          check("hex_event_data", {16'h0, h_data}, e.data);
        end
      end
      if (b_valid | b_cerr | b_lerr | b_terr) begin
        if (q_bin.size() == 0)
          check("bin_unexpected_event", {28'h0, b_valid, b_cerr, b_lerr, b_terr}, 32'd0);
        else begin
          e = q_bin.pop_front();
          check("bin_event_kind", {28'h0, b_valid, b_cerr, b_lerr, b_terr}, {28'h0, e.flags});
          check("bin_event_data", {8'h0, b_data}, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_data_out", {16'h0, h_data}, 32'd0);
    check("reset_busy", {31'h0, h_busy}, 32'd0);
    check("reset_packet_count", {16'h0, h_pcnt}, 32'd0);
    check("reset_valid", {31'h0, h_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic hex packet, with one-cycle latency and single-cycle pulse checks.
    send_h("1");
    check("busy_mid_packet", {31'h0, h_busy}, 32'd1);
    send_h("2"); send_h("A"); send_h("B");
    valid_pkt(16'h12AB);
    send_h(8'h0D);
    check("latency_valid_high", {31'h0, h_valid}, 32'd1);
    check("latency_busy_low", {31'h0, h_busy}, 32'd0);
    @(negedge clk);
    check("valid_one_cycle", {31'h0, h_valid}, 32'd0);
    drain_and_check("hex_basic");

    // Short packet then a good one.
    push_hex(EV_LERR, 16'h12AB);
    send_h("1"); send_h("2"); send_h("a"); send_h(8'h0D);
    valid_pkt(16'hABCD);
    send_h("a"); send_h("b"); send_h("c"); send_h("d"); send_h(8'h0D);
    drain_and_check("hex_short");

    // Bad character, skipped to terminator, then a good packet.
    push_hex(EV_CERR, 16'hABCD);
    send_h("1"); send_h("G"); send_h("4"); send_h(8'h0D);
    valid_pkt(16'h5678);
    send_h("5"); send_h("6"); send_h("7"); send_h("8"); send_h(8'h0D);
    drain_and_check("hex_char_err");

    // Stray terminator in IDLE and line feeds everywhere are ignored.
    send_h(8'h0D); send_h(8'h0A);
    valid_pkt(16'h9876);
    send_h("9"); send_h(8'h0A); send_h("8"); send_h("7"); send_h(8'h0A); send_h("6"); send_h(8'h0D);
    drain_and_check("hex_lf_cr_ignored");

    // Overlong packet: saturating count gives length error.
    push_hex(EV_LERR, 16'h9876);
    send_h("1"); send_h("2"); send_h("3"); send_h("4"); send_h("5"); send_h(8'h0D);
    valid_pkt(16'h0EFF);
    send_h("0"); send_h("e"); send_h("F"); send_h("f"); send_h(8'h0D);
    drain_and_check("hex_overlong_case");

    // Binary framing, back-to-back, including terminator-like bytes and a gap.
    exp_bpcnt = exp_bpcnt + 16'd1;
    push_bin(EV_VALID, 24'h123456);
    send_b(8'h12); send_b(8'h34); send_b(8'h56);
    check("bin_latency_valid", {31'h0, b_valid}, 32'd1);
    exp_bpcnt = exp_bpcnt + 16'd1;
    push_bin(EV_VALID, 24'h0D0AFF);
    send_b(8'h0D); send_b(8'h0A); send_b(8'hFF);
    exp_bpcnt = exp_bpcnt + 16'd1;
    push_bin(EV_VALID, 24'hAABBCC);
    send_b(8'hAA);
    repeat (3) @(negedge clk);
    check("bin_busy_gap", {31'h0, b_busy}, 32'd1);
    send_b(8'hBB); send_b(8'hCC);
    repeat (3) @(negedge clk);
    #1;
    check("bin_queue_empty", 32'(q_bin.size()), 32'd0);
    check("bin_data_out", {8'h0, b_data}, 32'h00AABBCC);
    check("bin_packet_count", {16'h0, b_pcnt}, {16'h0, exp_bpcnt});

    // Mid-packet idle: timeout when built in, otherwise the packet keeps waiting.
    send_h("1"); send_h("2");
`ifdef RX_PACKET_TIMEOUT_EN
    push_hex(EV_TERR, 16'h0EFF);
    repeat (8) @(negedge clk);
    check("timeout_pulse", {31'h0, h_terr}, 32'd1);
    @(negedge clk);
    check("timeout_busy", {31'h0, h_busy}, 32'd0);
    valid_pkt(16'hFFFF);
`else
    repeat (9) @(negedge clk);
    check("no_timeout_pulse", {31'h0, h_terr}, 32'd0);
    check("no_timeout_busy", {31'h0, h_busy}, 32'd1);
    push_hex(EV_LERR, 16'h0EFF);
`endif
    send_h("F"); send_h("F"); send_h("F"); send_h("F"); send_h(8'h0D);
    drain_and_check("hex_after_idle");

    // Reset mid-packet, with a byte strobed during the reset cycle.
    send_h("1"); send_h("2");
    rst     = 1'b1;
    h_rxreg = "9";
    h_rxif  = 1'b1;
    @(negedge clk);
    h_rxif  = 1'b0;
    rst     = 1'b0;
    exp_hpcnt = 16'd0;
    exp_hdata = 16'd0;
    check("rst_data_out", {16'h0, h_data}, 32'd0);
    check("rst_packet_count", {16'h0, h_pcnt}, 32'd0);
    check("rst_busy", {31'h0, h_busy}, 32'd0);
    check("rst_pulses", {28'h0, h_valid, h_cerr, h_lerr, h_terr}, 32'd0);
    check("rst_bin_data_out", {8'h0, b_data}, 32'd0);
    check("rst_bin_packet_count", {16'h0, b_pcnt}, 32'd0);
    valid_pkt(16'h0001);
    send_h("0"); send_h("0"); send_h("0"); send_h("1"); send_h(8'h0D);
    drain_and_check("hex_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
